// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle RISC-V controller: opcodes, ALU codes,
// FSM state encodings and the instruction field layout.
package ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned STATE_W = 3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    typedef enum logic [ALU_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SRL = 4'b1000,
        ALU_SLL = 4'b1001,
        ALU_SRA = 4'b1010,
        ALU_XOR = 4'b1101
    } alu_op_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd7
    } state_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv_instr_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface multicycle_ctrl_if
    import ctrl_pkg::*;
#(
    parameter int unsigned INSTRET_WIDTH = 32
);
    logic [XLEN-1:0]          instr_in;
    logic                     Zero;
    logic                     mem_ready;
    logic [XLEN-1:0]          instr;
    logic                     PCSrc;
    logic                     ALUSrc;
    logic                     RegWrite;
    logic                     MemToReg;
    logic [ALU_W-1:0]         ALUCtrl;
    logic                     loadPC;
    logic                     MemRead;
    logic                     MemWrite;
    logic [STATE_W-1:0]       state;
    logic                     illegal;
    logic [INSTRET_WIDTH-1:0] instret;

    modport master (
        input  instr_in, Zero, mem_ready,
        output instr, PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl,
               loadPC, MemRead, MemWrite, state, illegal, instret
    );

    modport slave (
        output instr_in, Zero, mem_ready,
        input  instr, PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl,
               loadPC, MemRead, MemWrite, state, illegal, instret
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode with a legality flag for the supported
// RV32I subset.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic [6:0]       i_funct7,
    output logic [ALU_W-1:0] o_alu_ctrl_c,
    output logic             o_legal_c
);
    alu_op_e w_alu;
    logic    w_legal;

    always_comb begin
        w_alu   = ALU_ADD;
        w_legal = 1'b0;
        case (i_opcode)
            OP_R: begin
                if (i_funct7 == F7_ZERO) begin
                    w_legal = 1'b1;
                    case (i_funct3)
                        3'b000:  w_alu = ALU_ADD;
                        3'b001:  w_alu = ALU_SLL;
                        3'b010:  w_alu = ALU_SLT;
                        3'b100:  w_alu = ALU_XOR;
                        3'b101:  w_alu = ALU_SRL;
                        3'b110:  w_alu = ALU_OR;
                        3'b111:  w_alu = ALU_AND;
                        default: w_legal = 1'b0;
                    endcase
                end else if (i_funct7 == F7_ALT) begin
                    case (i_funct3)
                        3'b000:  begin w_alu = ALU_SUB; w_legal = 1'b1; end
                        3'b101:  begin w_alu = ALU_SRA; w_legal = 1'b1; end
                        default: w_legal = 1'b0;
                    endcase
                end
            end
            OP_I: begin
                // funct7 only matters for shifts; elsewhere it is immediate data
                w_legal = 1'b1;
                case (i_funct3)
                    3'b000: w_alu = ALU_ADD;
                    3'b010: w_alu = ALU_SLT;
                    3'b100: w_alu = ALU_XOR;
                    3'b110: w_alu = ALU_OR;
                    3'b111: w_alu = ALU_AND;
                    3'b001: begin
                        w_alu   = ALU_SLL;
                        w_legal = (i_funct7 == F7_ZERO);
                    end
                    3'b101: begin
                        w_alu   = (i_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        w_legal = (i_funct7 == F7_ZERO) || (i_funct7 == F7_ALT);
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                w_alu   = ALU_ADD;
                w_legal = (i_funct3 == F3_WORD);
            end
            OP_BRANCH: begin
                w_alu   = ALU_SUB;
                w_legal = (i_funct3 == F3_BEQ);
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign o_alu_ctrl_c = w_alu;
    assign o_legal_c    = w_legal;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB sequencer: owns the instruction register and
// drives the datapath controls and data-memory strobes.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned INSTRET_WIDTH = 32,
    parameter bit          WAIT_MEM      = 1'b1
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);
    state_e                   r_state;
    state_e                   w_state_nxt;
    rv_instr_t                r_instr;
    logic                     r_illegal;
    logic [INSTRET_WIDTH-1:0] r_instret;

    logic [ALU_W-1:0] w_alu_ctrl;
    logic             w_legal;
    logic             w_is_r;
    logic             w_is_load;
    logic             w_is_store;
    logic             w_is_branch;
    logic             w_mem_done;
    logic             w_load_ir;
    logic             w_set_illegal;
    logic             w_retire;
    logic             w_pcsrc;
    logic             w_alusrc;
    logic             w_regwrite;
    logic             w_memtoreg;
    logic             w_memread;
    logic             w_memwrite;

    alu_decoder u_alu_dec (
        .i_opcode     (r_instr.opcode),
        .i_funct3     (r_instr.funct3),
        .i_funct7     (r_instr.funct7),
        .o_alu_ctrl_c (w_alu_ctrl),
        .o_legal_c    (w_legal)
    );

    assign w_is_r      = (r_instr.opcode == OP_R);
    assign w_is_load   = (r_instr.opcode == OP_LOAD);
    assign w_is_store  = (r_instr.opcode == OP_STORE);
    assign w_is_branch = (r_instr.opcode == OP_BRANCH);
    assign w_mem_done  = (WAIT_MEM == 1'b0) || bus.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IF;
        else     r_state <= w_state_nxt;
    end

    // Instruction register, sticky illegal flag and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr   <= '0;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            if (w_load_ir)     r_instr   <= rv_instr_t'(bus.instr_in);
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_retire)      r_instret <= r_instret + INSTRET_WIDTH'(1);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_ir     = 1'b0;
        w_set_illegal = 1'b0;
        w_retire      = 1'b0;
        w_pcsrc       = 1'b0;
        w_alusrc      = 1'b0;
        w_regwrite    = 1'b0;
        w_memtoreg    = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        case (r_state)
            ST_IF: begin
                w_load_ir   = 1'b1;
                w_state_nxt = ST_ID;
            end
            ST_ID: begin
                if (w_legal) begin
                    w_state_nxt = ST_EX;
                end else begin
                    w_state_nxt   = ST_HALT;
                    w_set_illegal = 1'b1;
                end
            end
            ST_EX: begin
                w_alusrc = !(w_is_r || w_is_branch);
                if (w_is_branch) begin
                    w_retire    = 1'b1;
                    w_pcsrc     = bus.Zero;
                    w_state_nxt = ST_IF;
                end else if (w_is_load || w_is_store) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                w_alusrc   = 1'b1;
                w_memread  = w_is_load;
                w_memwrite = w_is_store;
                if (w_mem_done) begin
                    if (w_is_load) begin
                        w_state_nxt = ST_WB;
                    end else begin
                        w_retire    = 1'b1;
                        w_state_nxt = ST_IF;
                    end
                end
            end
            ST_WB: begin
                w_alusrc    = !w_is_r;
                w_regwrite  = 1'b1;
                w_memtoreg  = w_is_load;
                w_retire    = 1'b1;
                w_state_nxt = ST_IF;
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IF;
        endcase
    end

    // Strobes are forced low during reset so an aborted instruction has no side effects
    assign bus.loadPC   = w_retire   & ~rst;
    assign bus.PCSrc    = w_pcsrc    & ~rst;
    assign bus.RegWrite = w_regwrite & ~rst;
    assign bus.MemRead  = w_memread  & ~rst;
    assign bus.MemWrite = w_memwrite & ~rst;
    assign bus.ALUSrc   = w_alusrc;
    assign bus.MemToReg = w_memtoreg;
    assign bus.ALUCtrl  = w_alu_ctrl;
    assign bus.instr    = r_instr;
    assign bus.state    = r_state;
    assign bus.illegal  = r_illegal;
    assign bus.instret  = r_instret;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM that sequences the single-issue RISC-V datapath through IF/ID/EX/MEM/WB.
- Latches the fetched instruction into an instruction register and decodes it.
- Drives PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl and loadPC, plus data-memory strobes.
- Sits between instruction ROM / data RAM and the datapath inside the processor top.

Parameters:
INSTRET_WIDTH, 32, width of the retired-instruction counter
WAIT_MEM, 1, 1: MEM state waits for mem_ready; 0: MEM lasts exactly one cycle and mem_ready is ignored

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
instr_in  in  32  instruction word from ROM at current PC
Zero  in  1  ALU zero flag from datapath
mem_ready  in  1  data RAM done for current MemRead/MemWrite
instr  out  32  instruction register contents, feeds datapath instr
PCSrc  out  1  1: PC <= PC + branch offset
ALUSrc  out  1  1: ALU op2 = immediate
RegWrite  out  1  register-file write enable
MemToReg  out  1  1: write-back from dReadData
ALUCtrl  out  4  ALU operation code
loadPC  out  1  PC update enable, one cycle per instruction
MemRead  out  1  data RAM read strobe
MemWrite  out  1  data RAM write strobe
state  out  3  current FSM state (debug)
illegal  out  1  sticky unsupported-opcode/funct flag
instret  out  INSTRET_WIDTH  count of retired instructions

Behaviour:
- Reset: state=IF, instr=0, illegal=0, instret=0. All strobes (loadPC, RegWrite, MemRead, MemWrite, PCSrc) are 0 while in rst.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7.
- IF: instr <= instr_in at end of cycle; next state ID.
- ID: decode instr.
  - Legal: next EX.
  - Unsupported opcode or funct3/funct7: next HALT, illegal <= 1.
- Supported instructions:
  - R-type: add sub and or xor slt sll srl sra.
  - I-ALU: addi andi ori xori slti slli srli srai.
  - Memory and branch: lw, sw, beq.
- EX transitions:
  - R and I-ALU: next WB.
  - lw and sw: next MEM.
  - beq: retires in EX, next IF.
- MEM:
  - MemRead=1 (lw) or MemWrite=1 (sw) held every cycle until mem_ready=1; stay in MEM while mem_ready=0.
  - On mem_ready=1: lw goes to WB; sw retires and goes to IF.
  - WAIT_MEM=0: one cycle, mem_ready treated as 1.
- WB: RegWrite=1 for one cycle, MemToReg=1 for lw only, then retire and go to IF.
- HALT: all strobes 0, stays until rst.
- Retire cycle (WB for R/I/lw; MEM handshake cycle for sw; EX for beq):
  - loadPC=1 and instret <= instret+1, wrapping modulo 2^INSTRET_WIDTH.
  - loadPC is 0 in every other cycle.
- PCSrc = (state==EX) and beq and Zero; 0 otherwise, including when loadPC=0.
- Cycle counts:
  - R/I: 4 cycles; beq: 3; sw: 4 + wait; lw: 5 + wait (wait=0 when mem_ready is already high).
- ALUSrc=1 for I-ALU, lw, sw in EX/MEM/WB; 0 for R and beq.
- ALUCtrl is held stable from EX through retire. Mapping:
  - add/addi/lw/sw -> ADD; sub/beq -> SUB; and/andi -> AND; or/ori -> OR; xor/xori -> XOR; slt/slti -> SLT.
  - sll/slli -> SLL; srl/srli -> SRL; sra/srai -> SRA.
  - srai and sra are distinguished by instr[30].
- Controls are combinational from registered state/instr (PCSrc also from Zero). There are no output registers besides instr, state, illegal and instret.
- rst asserted mid-instruction (any state, including a MEM wait) aborts at the next edge: no loadPC, RegWrite or MemWrite in the reset cycle.
- mem_ready outside MEM is ignored.

Decomposition:
- Package ctrl_pkg: opcode constants (OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011).
- Package ctrl_pkg: ALU codes (AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SRL=1000, SLL=1001, SRA=1010, XOR=1101).
- Package ctrl_pkg: state encodings.
- One sub-module, alu_decoder: combinational (opcode, funct3, funct7) -> ALUCtrl plus a legal flag. The FSM stays in multicycle_ctrl.

Test Plan:
- rst high 2 cycles, then release with instr_in=add x3,x1,x2 (0x002081B3) -> states IF,ID,EX,WB; ALUCtrl=0010, ALUSrc=0 in EX; RegWrite=1 and loadPC=1 only in WB; instret=1.
- lw x5,8(x1) with mem_ready low 3 MEM cycles -> MemRead=1 for 4 cycles, then WB with MemToReg=1, RegWrite=1; total 8 cycles; ALUSrc=1, ALUCtrl=0010.
- beq x1,x2 with Zero=1 in EX -> PCSrc=1, loadPC=1 in cycle 3; repeat with Zero=0 -> PCSrc=0, loadPC=1; instret increments both times.
- sw with mem_ready=1 immediately -> MemWrite=1 and loadPC=1 same cycle, RegWrite never 1; 4 cycles.
- Instruction 0xFFFFFFFF -> HALT after ID, illegal=1, no strobes for 20 cycles; rst -> IF, illegal=0.
- rst asserted during lw MEM wait -> next cycle state=IF, MemRead=0, instret unchanged.
- instret preset near wrap (INSTRET_WIDTH=4, 15 retires then 1 more) -> instret=0.
